// File: rtl/hazard_scoreboard_if.sv
// Issue-side bundle between the OF stage and the hazard scoreboard.
// The master drives the issuing instruction; the slave returns forwarding and stall decisions.
interface hazard_scoreboard_if #(
    parameter int NREGS = 16,
    parameter int AW    = 4,
    parameter int DEPTH = 3,
    parameter int CNT_W = 16
);
    localparam int SW = $clog2(DEPTH + 1);

    logic             issue_valid;
    logic             issue_we;
    logic [AW-1:0]    issue_rd;
    logic             issue_ld;
    logic             src1_valid;
    logic [AW-1:0]    src1;
    logic             src2_valid;
    logic [AW-1:0]    src2;
    logic             flush;
    logic             stall;
    logic [SW-1:0]    fwd1_sel;
    logic [SW-1:0]    fwd2_sel;
    logic [NREGS-1:0] busy_vec;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_ld,
        output src1_valid, src1, src2_valid, src2, flush,
        input  stall, fwd1_sel, fwd2_sel, busy_vec, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_ld,
        input  src1_valid, src1, src2_valid, src2, flush,
        output stall, fwd1_sel, fwd2_sel, busy_vec, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: per-source forwarding select, load-use stall,
// busy-register vector and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int NREGS       = 16,
    parameter int AW          = 4,
    parameter int DEPTH       = 3,
    parameter int LD_READY    = 1,
    parameter int ZERO_REG_EN = 0,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    hazard_scoreboard_if.slave bus
);
    localparam int SW = $clog2(DEPTH + 1);

    logic [DEPTH:1]   ent_v;
    logic [DEPTH:1]   ent_ld;
    logic [AW-1:0]    ent_rd [1:DEPTH];
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_now;
    logic [SW-1:0]    sel1;
    logic [SW-1:0]    sel2;
    logic             ld1;
    logic             ld2;
    logic             zero1;
    logic             zero2;
    logic [NREGS-1:0] busy;

    assign zero1 = (ZERO_REG_EN != 0) && (bus.src1 == '0);
    assign zero2 = (ZERO_REG_EN != 0) && (bus.src2 == '0);

    // Scan oldest to youngest so the last hit written is the youngest writer.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        ld1  = 1'b0;
        ld2  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (bus.src1_valid && bus.issue_valid && ent_v[k] &&
                ent_rd[k] == bus.src1 && !zero1) begin
                sel1 = SW'(k);
                ld1  = ent_ld[k];
            end
            if (bus.src2_valid && bus.issue_valid && ent_v[k] &&
                ent_rd[k] == bus.src2 && !zero2) begin
                sel2 = SW'(k);
                ld2  = ent_ld[k];
            end
        end
    end

    always_comb begin
        stall_now = 1'b0;
        if (bus.issue_valid && !bus.flush) begin
            if (ld1 && int'(sel1) <= LD_READY)
                stall_now = 1'b1;
            if (ld2 && int'(sel2) <= LD_READY)
                stall_now = 1'b1;
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (ent_v[k])
                busy[ent_rd[k]] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_v     <= '0;
            ent_ld    <= '0;
            for (int k = 1; k <= DEPTH; k++)
                ent_rd[k] <= '0;
            stall_cnt <= '0;
        end else begin
            // A stalled or flushed issue enters the pipe as a bubble.
            ent_v[1]  <= bus.issue_valid & bus.issue_we & ~stall_now & ~bus.flush;
            ent_rd[1] <= bus.issue_rd;
            ent_ld[1] <= bus.issue_ld;
            for (int k = 2; k <= DEPTH; k++) begin
                ent_v[k]  <= ent_v[k-1];
                ent_rd[k] <= ent_rd[k-1];
                ent_ld[k] <= ent_ld[k-1];
            end
            if (stall_now && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall     = stall_now;
    assign bus.fwd1_sel  = sel1;
    assign bus.fwd2_sel  = sel2;
    assign bus.busy_vec  = busy;
    assign bus.stall_cnt = stall_cnt;
endmodule
